// File: rtl/led_req_arbiter.sv
// Round-robin arbiter that shares one LED pattern slave between NUM_REQ requesters.
// Each forwarded pattern is followed by HOLD_CYCLES idle cycles so it stays visible.
module led_req_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int HOLD_CYCLES = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [2*NUM_REQ-1:0]       req_data,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic [1:0]                 m_data,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       busy
);
   localparam int GW = $clog2(NUM_REQ);
   localparam int CW = $clog2(HOLD_CYCLES) + 1;
   localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYCLES - 1);
   localparam logic [GW-1:0] LAST_RST = GW'(NUM_REQ - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SEND = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;

   logic [1:0]    r_state;
   logic [GW-1:0] r_last;
   logic [GW-1:0] r_gid;
   logic [1:0]    r_mdata;
   logic [CW-1:0] r_cnt;

   logic          w_found;
   logic [GW-1:0] w_win;
   logic [1:0]    w_wdata;

   // Search starts just after the last winner and wraps, giving round-robin order.
   always_comb begin
      int idx;
      idx     = 0;
      w_found = 1'b0;
      w_win   = '0;
      w_wdata = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(r_last) + k) % NUM_REQ;
         if (!w_found && req_valid[idx]) begin
            w_found = 1'b1;
            w_win   = idx[GW-1:0];
            w_wdata = req_data[2*idx +: 2];
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (!rst && r_state == S_IDLE && w_found)
         req_ready[w_win] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_last  <= LAST_RST;
         r_gid   <= '0;
         r_mdata <= '0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (w_found) begin
               r_mdata <= w_wdata;
               r_gid   <= w_win;
               r_last  <= w_win;
               r_state <= S_SEND;
            end
            S_SEND: if (m_ready) begin
               r_cnt   <= HOLD_LD;
               r_state <= S_HOLD;
            end
            S_HOLD: begin
               if (r_cnt == '0) r_state <= S_IDLE;
               else             r_cnt   <= r_cnt - CW'(1);
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign m_valid  = (r_state == S_SEND);
   assign busy     = (r_state != S_IDLE);
   assign m_data   = r_mdata;
   assign grant_id = r_gid;
endmodule

// File: doc/led_req_arbiter.md
# led_req_arbiter

Round-robin arbiter that shares the single LED pattern slave (valid/ready handshake, 2-bit pattern code decoded to four LEDs) between several requesters, e.g. fabric switches, the MSS/AXI register path and the logic-analyzer test driver. It accepts one pattern from one requester, forwards it downstream, then holds off further grants for a programmable number of cycles so every pattern stays on the LEDs long enough to be seen. It sits between the requester logic and the LED slave in the fabric top level.

## Interface

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- HOLD_CYCLES, 8, cycles of enforced idle after each completed downstream transfer; legal range 1..2^16.

Ports:
- clk  in  1  fabric clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  NUM_REQ  bit i: requester i has a pattern pending.
- req_data  in  2*NUM_REQ  requester i pattern code at bits [2i+1:2i].
- req_ready  out  NUM_REQ  bit i: requester i pattern accepted this cycle (at most one bit high).
- m_valid  out  1  downstream pattern valid.
- m_ready  in  1  downstream slave ready.
- m_data  out  2  downstream pattern code.
- grant_id  out  clog2(NUM_REQ)  index of the requester currently or most recently served.
- busy  out  1  high whenever state is not IDLE.

## Operation

- States: IDLE, SEND, HOLD. Single state register; busy = (state != IDLE).
- IDLE: m_valid=0. If any req_valid bit is high, the winner is the first set bit searching last_grant+1, last_grant+2, … modulo NUM_REQ. req_ready[winner] is high in that same cycle (combinational from state and req_valid); all other req_ready bits are 0. Transfer from the requester = req_valid & req_ready. On that edge: latch req_data of the winner into m_data, set grant_id and last_grant to the winner, and go to SEND.
- SEND: m_valid=1; m_data and grant_id are stable. Stay in SEND until m_valid & m_ready. On the handshake edge: load hold counter with HOLD_CYCLES-1 and go to HOLD.
- HOLD: m_valid=0. The counter decrements each cycle. In the cycle where the counter is 0, go to IDLE.
- Outside IDLE, req_ready is all 0. Requesters keep req_valid and req_data asserted until they see req_ready.
- Deasserting req_valid or changing req_data during SEND or HOLD has no effect, because the data is already latched.
- m_ready while m_valid=0 is ignored.
- Counter width is clog2(HOLD_CYCLES)+1. It is unsigned, and no wrap occurs.
- Reset values: state=IDLE, m_valid=0, m_data=2'b00, grant_id=0, busy=0, last_grant=NUM_REQ-1 (so requester 0 wins first), counter=0, req_ready=0 while rst=1.
- Reset mid-SEND or mid-HOLD: return to IDLE on the next edge and drop m_valid. The abandoned pattern is not replayed, and the requester is not re-accepted.

## Timing

- Requester accept at cycle T. m_valid=1 from T+1.
- With the LED slave (ready is the registered copy of valid), m_ready=1 at T+2 and the handshake completes at T+2.
- HOLD occupies cycles T+3 .. T+2+HOLD_CYCLES. IDLE is at T+3+HOLD_CYCLES, where the next accept can happen in the same cycle.
- Grant-to-grant period with the LED slave is HOLD_CYCLES+3 (11 at default). With m_ready tied high it is HOLD_CYCLES+2.
- There is no bypass: a single request never reaches m_valid in the cycle it is accepted.
- Fairness: under continuous requests from all NUM_REQ requesters, each is served exactly once per NUM_REQ grants.

## Test plan

- Single requester: req_valid=0001, req_data[1:0]=2'b10. Required: req_ready=0001 in the same cycle; m_valid=1 with m_data=2'b10 and grant_id=0 one cycle later; with the LED slave, the handshake lands 2 cycles after accept and the next accept cannot occur until 11 cycles after the first.
- All four requesting continuously, with patterns 00/01/10/11. Required: grant order 0,1,2,3,0,1; m_data sequence 00,01,10,11,00,01; grant spacing 11 cycles each.
- Requesters 1 and 3 only, after a grant to 2. Required: 3 wins first, then 1, then 3. Requester 0 never sees req_ready.
- Downstream stall: m_ready held 0 for 20 cycles in SEND. Required: m_valid stays 1, m_data and grant_id do not change, and req_ready stays 0 throughout. On m_ready=1 the block enters HOLD the next cycle.
- rst=1 asserted for one cycle during SEND, then released with req_valid=0000. Required: m_valid=0, busy=0, grant_id=0 from the next cycle, and no further m_valid pulse; the next request from 0 is served first.
- HOLD_CYCLES=1 with m_ready tied 1 and constant requests. Required: grant period of exactly 3 cycles.
